// File: rtl/bus_drvr_endpoint.sv
// Bus terminal endpoint: host-fed TX FIFO presented to the bus as pndng/D_pop,
// and an RX FIFO filled by bus push strobes and drained through a valid/ready port.
module bus_drvr_endpoint #(
    parameter int bits  = 16,
    parameter int depth = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [bits-1:0]         in_data,
    output logic                    in_ready,
    output logic                    pndng,
    output logic [bits-1:0]         D_pop,
    input  logic                    pop,
    input  logic                    push,
    input  logic [bits-1:0]         D_push,
    output logic                    out_valid,
    output logic [bits-1:0]         out_data,
    input  logic                    out_ready,
    output logic [$clog2(depth):0]  tx_count,
    output logic [$clog2(depth):0]  rx_count,
    output logic                    ovf,
    output logic                    udf
);

    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(depth);

    logic [bits-1:0] tx_mem [depth];
    logic [bits-1:0] rx_mem [depth];

    logic [AW-1:0] tx_wr, tx_rd;
    logic [AW-1:0] rx_wr, rx_rd;

    logic tx_wr_en, tx_rd_en;
    logic rx_wr_en, rx_rd_en;

    // Status flags come only from registered counts, so no strobe reaches an output.
    assign in_ready  = (tx_count != FULL);
    assign pndng     = (tx_count != '0);
    assign out_valid = (rx_count != '0);

    // Empty FIFOs present zero so outputs stay defined before the arrays are written.
    assign D_pop    = pndng     ? tx_mem[tx_rd] : '0;
    assign out_data = out_valid ? rx_mem[rx_rd] : '0;

    assign tx_wr_en = in_valid & in_ready;
    assign tx_rd_en = pop & pndng;
    assign rx_rd_en = out_valid & out_ready;
    // A full RX FIFO still accepts a push when the host frees the head slot in the same cycle.
    assign rx_wr_en = push & ((rx_count != FULL) | rx_rd_en);

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_count <= '0;
            udf      <= 1'b0;
        end else begin
            if (tx_wr_en) begin
                tx_wr <= tx_wr + AW'(1);
            end
            if (tx_rd_en) begin
                tx_rd <= tx_rd + AW'(1);
            end
            case ({tx_wr_en, tx_rd_en})
                2'b10:   tx_count <= tx_count + CW'(1);
                2'b01:   tx_count <= tx_count - CW'(1);
                default: tx_count <= tx_count;
            endcase
            if (pop && !pndng) begin
                udf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_count <= '0;
            ovf      <= 1'b0;
        end else begin
            if (rx_wr_en) begin
                rx_wr <= rx_wr + AW'(1);
            end
            if (rx_rd_en) begin
                rx_rd <= rx_rd + AW'(1);
            end
            case ({rx_wr_en, rx_rd_en})
                2'b10:   rx_count <= rx_count + CW'(1);
                2'b01:   rx_count <= rx_count - CW'(1);
                default: rx_count <= rx_count;
            endcase
            if (push && !rx_wr_en) begin
                ovf <= 1'b1;
            end
        end
    end

    // Storage carries no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clock) begin
        if (tx_wr_en && !reset) begin
            tx_mem[tx_wr] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rx_wr_en && !reset) begin
            rx_mem[rx_wr] <= D_push;
        end
    end

endmodule

// File: tb/tb_bus_drvr_endpoint.sv
// Directed bench for bus_drvr_endpoint: queue-based model checked every cycle,
// plus literal expectations along the test plan sequences.
module tb_bus_drvr_endpoint;

    localparam int BITS  = 16;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic            clock = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [BITS-1:0] in_data;
    logic            in_ready;
    logic            pndng;
    logic [BITS-1:0] D_pop;
    logic            pop;
    logic            push;
    logic [BITS-1:0] D_push;
    logic            out_valid;
    logic [BITS-1:0] out_data;
    logic            out_ready;
    logic [CW-1:0]   tx_count;
    logic [CW-1:0]   rx_count;
    logic            ovf;
    logic            udf;

    int n_vec  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    logic [BITS-1:0] txq[$];
    logic [BITS-1:0] rxq[$];
    bit              m_ovf;
    bit              m_udf;

    bus_drvr_endpoint #(.bits(BITS), .depth(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .pndng     (pndng),
        .D_pop     (D_pop),
        .pop       (pop),
        .push      (push),
        .D_push    (D_push),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .tx_count  (tx_count),
        .rx_count  (rx_count),
        .ovf       (ovf),
        .udf       (udf)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: two plain queues, updated with the same inputs the DUT sees at each edge.
    always @(posedge clock) begin : model_upd
        bit tx_acc, tx_take, rx_take, rx_acc;
        if (reset) begin
            txq.delete();
            rxq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            tx_acc  = in_valid && (txq.size() < DEPTH);
            tx_take = pop && (txq.size() > 0);
            rx_take = out_ready && (rxq.size() > 0);
            rx_acc  = push && ((rxq.size() < DEPTH) || rx_take);
            if (pop && txq.size() == 0) m_udf = 1'b1;
            if (push && !rx_acc) m_ovf = 1'b1;
            if (tx_take) void'(txq.pop_front());
            if (tx_acc) txq.push_back(in_data);
            if (rx_take) void'(rxq.pop_front());
            if (rx_acc) rxq.push_back(D_push);
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("m_tx_count", 32'(tx_count), 32'(txq.size()));
            check("m_rx_count", 32'(rx_count), 32'(rxq.size()));
            check("m_pndng", 32'(pndng), 32'(txq.size() != 0));
            check("m_out_valid", 32'(out_valid), 32'(rxq.size() != 0));
            check("m_in_ready", 32'(in_ready), 32'(txq.size() != DEPTH));
            check("m_ovf", 32'(ovf), 32'(m_ovf));
            check("m_udf", 32'(udf), 32'(m_udf));
            if (txq.size() != 0) check("m_D_pop", 32'(D_pop), 32'(txq[0]));
            else                 check("m_D_pop_known", 32'($isunknown(D_pop)), 32'd0);
            if (rxq.size() != 0) check("m_out_data", 32'(out_data), 32'(rxq[0]));
            else                 check("m_out_data_known", 32'($isunknown(out_data)), 32'd0);
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; pop = 1'b0;
        push = 1'b0; D_push = '0; out_ready = 1'b0;
        tick(); tick();
        chk_en = 1'b1;
        check("rst_pndng", 32'(pndng), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_counts", 32'({tx_count, rx_count}), 32'd0);
        check("rst_flags", 32'({ovf, udf}), 32'd0);
        reset = 1'b0;

        // Three host writes, then three back-to-back pops.
        in_valid = 1'b1; in_data = 16'h1111; tick();
        check("t1_pndng", 32'(pndng), 32'd1);
        check("t1_dpop0", 32'(D_pop), 32'h1111);
        in_data = 16'h2222; tick();
        in_data = 16'h3333; tick();
        in_valid = 1'b0; pop = 1'b1;
        check("t1_cnt3", 32'(tx_count), 32'd3);
        tick(); check("t1_dpop1", 32'(D_pop), 32'h2222);
        tick(); check("t1_dpop2", 32'(D_pop), 32'h3333);
        tick(); pop = 1'b0;
        check("t1_empty", 32'(pndng), 32'd0);
        check("t1_cnt0", 32'(tx_count), 32'd0);
        check("t1_udf", 32'(udf), 32'd0);

        // Fill TX, overfill attempt, pop one, write across the wrap.
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_data = 16'h00A1 + 16'(i); tick();
        end
        check("t2_full_rdy", 32'(in_ready), 32'd0);
        check("t2_full_cnt", 32'(tx_count), 32'd8);
        in_data = 16'hEEEE; tick();
        check("t2_extra_cnt", 32'(tx_count), 32'd8);
        in_valid = 1'b0; pop = 1'b1; tick(); pop = 1'b0;
        check("t2_rdy_after_pop", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_data = 16'h00A9; tick(); in_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            check("t2_order", 32'(D_pop), 32'h00A2 + 32'(i));
            pop = 1'b1; tick();
        end
        pop = 1'b0;
        check("t2_drained", 32'(pndng), 32'd0);

        // Two bus pushes held, then drained by the host.
        push = 1'b1; D_push = 16'hBEEF; tick();
        D_push = 16'hCAFE; tick(); push = 1'b0;
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_head", 32'(out_data), 32'hBEEF);
        check("t3_cnt", 32'(rx_count), 32'd2);
        out_ready = 1'b1; tick();
        check("t3_second", 32'(out_data), 32'hCAFE);
        tick(); out_ready = 1'b0;
        check("t3_empty", 32'(out_valid), 32'd0);

        // RX overflow, then push accepted at full because the head is freed.
        for (int i = 0; i < DEPTH; i++) begin
            push = 1'b1; D_push = 16'h00C0 + 16'(i); tick();
        end
        D_push = 16'hDEAD; tick();
        check("t4_ovf", 32'(ovf), 32'd1);
        check("t4_cnt_full", 32'(rx_count), 32'd8);
        D_push = 16'h0BAD; out_ready = 1'b1; tick();
        push = 1'b0; out_ready = 1'b0;
        check("t4_cnt_still", 32'(rx_count), 32'd8);
        check("t4_head", 32'(out_data), 32'h00C1);
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH - 1; i++) tick();
        check("t4_last", 32'(out_data), 32'h0BAD);
        tick(); out_ready = 1'b0;
        check("t4_empty", 32'(out_valid), 32'd0);

        // Pop with TX empty sets a sticky underflow.
        pop = 1'b1; tick(); pop = 1'b0;
        check("t5_udf", 32'(udf), 32'd1);
        check("t5_cnt", 32'(tx_count), 32'd0);
        check("t5_pndng", 32'(pndng), 32'd0);
        tick(); tick();
        check("t5_sticky", 32'(udf), 32'd1);

        // Reset mid-operation with strobes active.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 16'h5000 + 16'(i);
            push = (i < 2); D_push = 16'h6000 + 16'(i);
            tick();
        end
        in_valid = 1'b0; push = 1'b0;
        check("t6_pre_tx", 32'(tx_count), 32'd3);
        check("t6_pre_rx", 32'(rx_count), 32'd2);
        check("t6_pre_ovf", 32'(ovf), 32'd1);
        reset = 1'b1; pop = 1'b1; push = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        reset = 1'b0; pop = 1'b0; push = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("t6_counts", 32'({tx_count, rx_count}), 32'd0);
        check("t6_pndng", 32'(pndng), 32'd0);
        check("t6_out_valid", 32'(out_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        check("t6_flags", 32'({ovf, udf}), 32'd0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
